mul_div_unit: RTL

Iterative 32-bit unsigned multiply/divide execution unit for the datapath. It takes two operands read from the register file plus a destination register address, and computes the product (low or high word), quotient or remainder over a fixed 32-cycle iteration. It then drives a one-cycle write request (`wr_addr` / `wr_data` / `reg_write`) straight into the register file write port.

---
 rtl/mul_div_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : iterative 32-bit unsigned MUL/MULHU/DIVU/REMU, 32 iterations,
//                one-cycle register file write request on completion.
// Revision 1.0
// ============================================================================
`default_nettype none

module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        reg_write
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [31:0] b_q;
  logic [1:0]  op_q;
  logic [4:0]  rd_q;

  logic [32:0] mul_sum;
  logic [32:0] div_rem;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] acc_nxt;

  // acc holds {hi, lo} for multiply and {R, Q} for divide; op_q[1] picks divide
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_q} : 33'd0);
    div_rem = {acc[63:32], acc[31]};
    div_ge  = (div_rem >= {1'b0, b_q});
    div_sub = div_rem[31:0] - b_q;
    if (op_q[1]) begin
      if (div_ge) acc_nxt = {div_sub, acc[30:0], 1'b1};
      else        acc_nxt = {div_rem[31:0], acc[30:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[31:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 6'd0;
      acc       <= 64'd0;
      b_q       <= 32'd0;
      op_q      <= 2'd0;
      rd_q      <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reg_write <= 1'b0;
      wr_addr   <= 5'd0;
      wr_data   <= 32'd0;
    end else begin
      done      <= 1'b0;
      reg_write <= 1'b0;
      wr_addr   <= 5'd0;
      wr_data   <= 32'd0;
      case (state)
        S_IDLE: begin
          if (start && !kill) begin
            state <= S_RUN;
            busy  <= 1'b1;
            cnt   <= 6'd0;
            acc   <= {32'd0, a};
            b_q   <= b;
            op_q  <= op;
            rd_q  <= rd;
          end
        end
        S_RUN: begin
          if (kill) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 6'd1;
            // Last iteration: publish the result straight from acc_nxt
            if (cnt == 6'd31) begin
              state     <= S_DONE;
              done      <= 1'b1;
              reg_write <= (rd_q != 5'd0);
              wr_addr   <= rd_q;
              wr_data   <= op_q[0] ? acc_nxt[63:32] : acc_nxt[31:0];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
